// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the board LED mode controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF        = 2'd0,
    MODE_ON         = 2'd1,
    MODE_BLINK_SLOW = 2'd2,
    MODE_BLINK_FAST = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t cur);
    case (cur)
      MODE_OFF:        return MODE_ON;
      MODE_ON:         return MODE_BLINK_SLOW;
      MODE_BLINK_SLOW: return MODE_BLINK_FAST;
      default:         return MODE_OFF;
    endcase
  endfunction

  // LED level a mode starts with; blink modes start lit.
  function automatic logic entry_led(input mode_t m);
    return (m != MODE_OFF);
  endfunction

endpackage

// File: rtl/led_toggle_timer.sv
// Loadable up-counter that pulses tick for one cycle at terminal_count and wraps to 0.
module led_toggle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_s2_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] terminal_count,
  output logic         tick
);

  logic [W-1:0] count_reg;

  assign tick = enable && (count_reg == terminal_count);

  // Outside the blink modes the count rests at 0 so the next entry starts a full half-period.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      count_reg <= '0;
    end else if (clear || !enable || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// Board LED mode controller: each accepted press steps OFF->ON->BLINK_SLOW->BLINK_FAST->OFF.
// Optional press lockout window is built when LED_LOCKOUT_EN is defined.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int SLOW_TOGGLE_CYCLES = 12_500_000,
  parameter int FAST_TOGGLE_CYCLES = 2_500_000,
  parameter int LOCKOUT_CYCLES     = 1_000_000
) (
  input  logic       clock,
  input  logic       reset_s2_n,
  input  logic       button_pressed_s2,
  output logic       led,
  output logic [1:0] mode
);

  localparam int MAX_N = (SLOW_TOGGLE_CYCLES > FAST_TOGGLE_CYCLES) ?
                         SLOW_TOGGLE_CYCLES : FAST_TOGGLE_CYCLES;
  localparam int CW    = $clog2(MAX_N);

  if (SLOW_TOGGLE_CYCLES < 2 || FAST_TOGGLE_CYCLES < 2 || LOCKOUT_CYCLES < 1) begin : g_bad_param
    $error("led_mode_ctrl: toggle periods must be >= 2 and lockout >= 1");
  end

  mode_t        mode_reg, mode_next;
  logic         led_reg, led_next;
  logic         locked;
  logic         accept;
  logic         blink_en;
  logic         tick;
  logic [CW-1:0] terminal_count;

  assign accept         = button_pressed_s2 && !locked;
  assign blink_en       = (mode_reg == MODE_BLINK_SLOW) || (mode_reg == MODE_BLINK_FAST);
  assign terminal_count = (mode_reg == MODE_BLINK_FAST) ? CW'(FAST_TOGGLE_CYCLES - 1) :
                                                          CW'(SLOW_TOGGLE_CYCLES - 1);

  led_toggle_timer #(
    .W(CW)
  ) u_timer (
    .clock          (clock),
    .reset_s2_n     (reset_s2_n),
    .clear          (accept),
    .enable         (blink_en),
    .terminal_count (terminal_count),
    .tick           (tick)
  );

`ifdef LED_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [LW-1:0] lock_cnt_reg;

  assign locked = (lock_cnt_reg != '0);

  // Loaded on acceptance; the press arriving once it has drained to 0 is taken.
  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      lock_cnt_reg <= '0;
    end else if (accept) begin
      lock_cnt_reg <= LW'(LOCKOUT_CYCLES);
    end else if (locked) begin
      lock_cnt_reg <= lock_cnt_reg - 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      mode_reg <= MODE_OFF;
      led_reg  <= 1'b0;
    end else begin
      mode_reg <= mode_next;
      led_reg  <= led_next;
    end
  end

  // A press outranks a coincident terminal count: the new mode's entry level wins.
  always_comb begin
    mode_next = mode_reg;
    led_next  = led_reg;
    if (accept) begin
      mode_next = next_mode(mode_reg);
      led_next  = entry_led(mode_next);
    end else if (tick) begin
      led_next = ~led_reg;
    end
  end

  assign led  = led_reg;
  assign mode = mode_reg;

endmodule
